// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Fetch sequencer for a synchronous-read instruction memory (1-cycle read
//   latency, no enable). Drives the fetch address every cycle, tracks the one
//   read in flight, buffers returned words with their PCs in a small prefetch
//   FIFO and hands them to decode over a valid/ready handshake. A redirect
//   flushes the FIFO and discards the in-flight word.
//
//   Optional feature macro: IMEM_FETCH_PERF_EN (adds perf_fetched and
//   perf_flushes counter outputs).
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   fetch_en        permits new reads (an in-flight read still completes)
//   redirect_valid  one-cycle redirect pulse
//   redirect_addr   redirect target (bits [1:0] forced to 0)
//   mem_addr        combinational address to instruction memory
//   mem_rdata       memory data, valid the cycle after mem_addr
//   out_valid       FIFO head valid
//   out_ready       decode accepts head
//   out_instr       registered head instruction
//   out_pc          registered head PC
//   perf_fetched    (IMEM_FETCH_PERF_EN) pushes into the FIFO
//   perf_flushes    (IMEM_FETCH_PERF_EN) redirect cycles
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
`ifdef IMEM_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushes
`endif
);

   localparam int          AW  = $clog2(DEPTH);
   localparam int          PW  = AW + 1;
   localparam logic [31:0] NOP = 32'hE1A0_0000;

   logic [31:0]   fetch_pc;
   logic          inflight_q;
   logic [31:0]   inflight_pc;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] count;
   logic [PW-1:0] next_rd;
   logic [PW-1:0] next_wr;
   logic [PW:0]   occupancy;
   logic          pop;
   logic          push;
   logic          issue;

   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   instr_q [DEPTH];

   assign count     = wr_ptr - rd_ptr;
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q & ~redirect_valid;

   // Slots already committed after this cycle: stored words plus the word in
   // flight, minus the one leaving. A new read is issued only if it still has
   // a free slot to land in, so the FIFO can never overflow.
   assign occupancy = {1'b0, count} + {{PW{1'b0}}, inflight_q} - {{PW{1'b0}}, pop};
   assign issue     = fetch_en & (redirect_valid | (occupancy < (PW+1)'(DEPTH)));

   assign mem_addr  = redirect_valid ? (redirect_addr & 32'hFFFF_FFFC) : fetch_pc;

   // A redirect flushes by moving the read pointer up to the write pointer.
   assign next_rd   = redirect_valid ? wr_ptr : rd_ptr + {{(PW-1){1'b0}}, pop};
   assign next_wr   = wr_ptr + {{(PW-1){1'b0}}, push};

   // FIFO storage holds data only; validity lives in the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[wr_ptr[AW-1:0]]    <= inflight_pc;
         instr_q[wr_ptr[AW-1:0]] <= mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight_q  <= 1'b0;
         inflight_pc <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         out_instr   <= NOP;
         out_pc      <= 32'h0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            inflight_pc <= mem_addr;
            fetch_pc    <= mem_addr + 32'd4;
         end else if (redirect_valid) begin
            fetch_pc    <= mem_addr;
         end
         rd_ptr <= next_rd;
         wr_ptr <= next_wr;
         // Head registers load the next-cycle head. If the new head is the
         // word being pushed right now, it bypasses the storage array.
         if (next_rd != next_wr) begin
            if (push && (next_rd == wr_ptr)) begin
               out_pc    <= inflight_pc;
               out_instr <= mem_rdata;
            end else begin
               out_pc    <= pc_q[next_rd[AW-1:0]];
               out_instr <= instr_q[next_rd[AW-1:0]];
            end
         end
      end
   end

`ifdef IMEM_FETCH_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= 32'h0;
         perf_flushes <= 32'h0;
      end else begin
         if (push)
            perf_fetched <= perf_fetched + 32'd1;
         if (redirect_valid)
            perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Self-checking bench for imem_fetch_ctrl. A behavioural model (a queue of
//   {pc, instr} entries plus the in-flight read) predicts mem_addr, out_valid
//   and the head entry every cycle under directed and random stimulus.
//   Perf counters are checked when IMEM_FETCH_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP      = 32'hE1A0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
`ifdef IMEM_FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushes;
`endif

   imem_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef IMEM_FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_flushes   (perf_flushes)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory: synchronous read, 1-cycle latency.
   logic [31:0] imem [1024];
   always @(posedge clk) mem_rdata <= imem[mem_addr[11:2]];

   // Reference model
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t        mq[$];
   logic        m_infl;
   logic [31:0] m_ipc;
   logic [31:0] m_fpc;
   int          m_fetched;
   int          m_flushes;

   int errors = 0;
   int checks = 0;

   logic        last_v;
   logic [31:0] last_pc;
   logic [31:0] last_instr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_infl    = 1'b0;
      m_ipc     = RESET_PC;
      m_fpc     = RESET_PC;
      m_fetched = 0;
      m_flushes = 0;
   endtask

   // One clock cycle: drive inputs just after the falling edge, compare the
   // DUT against the model, then advance the model across the rising edge.
   task automatic cyc(input logic fe, input logic rv, input logic [31:0] ra, input logic rdy);
      logic [31:0] addr;
      logic        pop;
      logic        issue;
      int          sz;
      fetch_en       = fe;
      redirect_valid = rv;
      redirect_addr  = ra;
      out_ready      = rdy;
      #1;
      addr = rv ? {ra[31:2], 2'b00} : m_fpc;
      sz   = mq.size();
      chk("mem_addr", mem_addr, addr);
      chk("out_valid", {31'b0, out_valid}, {31'b0, sz != 0});
      if (sz != 0) begin
         chk("out_pc", out_pc, mq[0].pc);
         chk("out_instr", out_instr, mq[0].instr);
      end
      last_v     = out_valid;
      last_pc    = out_pc;
      last_instr = out_instr;
      @(posedge clk);
      pop   = (sz != 0) && rdy;
      issue = fe && (rv || (sz + int'(m_infl) - int'(pop) < DEPTH));
      if (pop) void'(mq.pop_front());
      if (rv) begin
         mq.delete();
         m_flushes++;
      end else if (m_infl) begin
         mq.push_back('{pc: m_ipc, instr: imem[m_ipc[11:2]]});
         m_fetched++;
      end
      if (issue) m_fpc = addr + 32'd4;
      else if (rv) m_fpc = addr;
      m_infl = issue;
      m_ipc  = addr;
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_pc"}, out_pc, 32'h0);
      chk({tag, "_instr"}, out_instr, NOP);
      chk({tag, "_addr"}, mem_addr, RESET_PC);
`ifdef IMEM_FETCH_PERF_EN
      chk({tag, "_perf_fetched"}, perf_fetched, 32'h0);
      chk({tag, "_perf_flushes"}, perf_flushes, 32'h0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) imem[i] = $urandom;
      imem[0] = 32'hE3A0_1005;
      imem[1] = 32'hE3A0_2003;
      rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
      redirect_addr = 32'h0; out_ready = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Boot: first word appears on the third model cycle after release.
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("boot_empty", {31'b0, last_v}, 32'd0);
      cyc(1, 0, 0, 1);
      chk("first_valid", {31'b0, last_v}, 32'd1);
      chk("first_pc", last_pc, 32'h0);
      chk("first_instr", last_instr, 32'hE3A0_1005);
      cyc(1, 0, 0, 1);
      chk("second_pc", last_pc, 32'h4);
      chk("second_instr", last_instr, 32'hE3A0_2003);

      // Backpressure: FIFO fills, head holds, no PCs lost.
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1);

      // Redirect while the FIFO is full.
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 32'h0000_004B, 0);
      cyc(1, 0, 0, 0);
      chk("redir_flushed", {31'b0, last_v}, 32'd0);
      cyc(1, 0, 0, 1);
      chk("redir_valid", {31'b0, last_v}, 32'd1);
      chk("redir_pc", last_pc, 32'h48);

      // fetch_en low: in-flight word delivered, then empty; then resume.
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      chk("fe_drained", {31'b0, last_v}, 32'd0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);

      // Wrap past the top of the address space.
      cyc(1, 1, 32'hFFFF_FFFC, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("wrap_pc0", last_pc, 32'hFFFF_FFFC);
      cyc(1, 0, 0, 1);
      chk("wrap_pc1", last_pc, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
             $urandom, $urandom_range(0, 9) < 7);

`ifdef IMEM_FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'(m_fetched));
      chk("perf_flushes", perf_flushes, 32'(m_flushes));
`endif

      // Asynchronous reset in the middle of traffic.
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
      fetch_en = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
